// File: rtl/scanline_pkg.sv
// Shared definitions for the scanline post-process path: scanline mode
// encodings and the arithmetic helpers used by the per-channel datapath.
package scanline_pkg;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_H   = 2'd1,
    SL_V   = 2'd2,
    SL_HV  = 2'd3
  } sl_mode_e;

  // Expand a 4-bit strength code to the output range: ((s+1) << (out_bits-4)) - 1.
  function automatic int unsigned str_expand(input logic [3:0] s,
                                             input int unsigned out_bits);
    int unsigned v;
    v = (32'(s) + 32'd1) << (out_bits - 32'd4);
    return v - 32'd1;
  endfunction

  // Channel times (fade+2), clamped to the largest out_bits-wide value.
  function automatic int unsigned fade_sat(input int unsigned pix,
                                           input int unsigned fade,
                                           input int unsigned out_bits);
    int unsigned prod;
    int unsigned max_v;
    prod  = pix * (fade + 32'd2);
    max_v = (32'd1 << out_bits) - 32'd1;
    return (prod > max_v) ? max_v : prod;
  endfunction

endpackage

// File: rtl/sl_phase_gen.sv
// Line/column phase generator: VSYNC and DE edge detection, col_id and
// line_id counters, frame parity and the configuration capture pulse.
module sl_phase_gen #(
  parameter int MULT_BITS = 3
) (
  input  logic                 PCLK,
  input  logic                 reset_n,
  input  logic                 VSYNC_in,
  input  logic                 DE_in,
  input  logic [MULT_BITS-1:0] hmult,
  input  logic [MULT_BITS-1:0] vmult,
  output logic                 cfg_cap,
  output logic [MULT_BITS-1:0] col_id,
  output logic [MULT_BITS-1:0] line_id,
  output logic                 frame_odd
);

  logic                 vs_q;
  logic                 de_q;
  logic                 de_fall;
  logic [MULT_BITS-1:0] col_cnt;
  logic [MULT_BITS-1:0] line_cnt;

  // Edges are seen on the raw input against its registered copy, so the
  // capture pulse lines up with the cycle the edge arrives on.
  assign cfg_cap = vs_q & ~VSYNC_in;
  assign de_fall = de_q & ~DE_in;

  // col_cnt already holds the phase of the pixel currently at the input.
  assign col_id  = DE_in ? col_cnt : '0;
  assign line_id = line_cnt;

  // Edge history, column/line counters and frame parity.
  always_ff @(posedge PCLK) begin
    // NOTE: state uses non-blocking assignments so every register here
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      col_cnt   <= '0;
      line_cnt  <= '0;
      frame_odd <= 1'b0;
    end else begin
      vs_q <= VSYNC_in;
      de_q <= DE_in;

      if (!DE_in || col_cnt == hmult) col_cnt <= '0;
      else                            col_cnt <= col_cnt + 1'b1;

      // Frame start wins over a coincident end-of-line.
      if (cfg_cap)      line_cnt <= '0;
      else if (de_fall) line_cnt <= (line_cnt == vmult) ? '0 : line_cnt + 1'b1;

      if (cfg_cap) frame_odd <= ~frame_odd;
    end
  end

endmodule

// File: rtl/scanline_pp.sv
// Output-domain post-process: fade, scanline darkening and border mask over
// a fixed four-stage pipeline, with configuration shadowed once per frame.
module scanline_pp
  import scanline_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int IN_BITS   = 4,
  parameter int FADE_BITS = 4,
  parameter int OUT_BITS  = 8,
  parameter int MULT_BITS = 3
) (
  input  logic                        PCLK,
  input  logic                        reset_n,
  input  logic [NUM_CH*IN_BITS-1:0]   pix_in,
  input  logic [FADE_BITS-1:0]        fade_in,
  input  logic                        HSYNC_in,
  input  logic                        VSYNC_in,
  input  logic                        DE_in,
  input  logic                        mask_en_in,
  input  logic [1:0]                  cfg_mode,
  input  logic                        cfg_alt,
  input  logic [3:0]                  cfg_str,
  input  logic [(1<<MULT_BITS)-1:0]   cfg_slmask,
  input  logic [MULT_BITS-1:0]        cfg_hmult,
  input  logic [MULT_BITS-1:0]        cfg_vmult,
  input  logic [3:0]                  cfg_mask_br,
  output logic [NUM_CH*OUT_BITS-1:0]  pix_out,
  output logic                        HSYNC_out,
  output logic                        VSYNC_out,
  output logic                        DE_out,
  output logic                        frame_odd
);

  localparam int PIX_W = NUM_CH * IN_BITS;
  localparam int OUT_W = NUM_CH * OUT_BITS;
  localparam int SLM_W = 1 << MULT_BITS;

  typedef struct packed {
    sl_mode_e             mode;
    logic                 alt;
    logic [3:0]           str;
    logic [SLM_W-1:0]     slmask;
    logic [MULT_BITS-1:0] hmult;
    logic [MULT_BITS-1:0] vmult;
    logic [3:0]           mask_br;
  } cfg_t;

  cfg_t                 sh;
  logic                 cfg_cap;
  logic [MULT_BITS-1:0] col_id;
  logic [MULT_BITS-1:0] line_id;

  // Stage registers
  logic [PIX_W-1:0]     s1_pix;
  logic [FADE_BITS-1:0] s1_fade;
  logic                 s1_hs, s1_vs, s1_de, s1_mask;
  logic [MULT_BITS-1:0] s1_col, s1_line;
  logic [OUT_W-1:0]     s2_p;
  logic                 s2_hs, s2_vs, s2_de, s2_mask;
  logic [MULT_BITS-1:0] s2_col, s2_line;
  logic [OUT_W-1:0]     s3_p;
  logic                 s3_hs, s3_vs, s3_de, s3_mask;

  // Per-channel next-stage values
  logic [OUT_W-1:0]     fade_nx;
  logic [OUT_W-1:0]     sl_nx;
  logic [OUT_W-1:0]     mask_nx;
  logic [OUT_BITS-1:0]  str_v;
  logic                 h_hit, v_hit, hit;

  sl_phase_gen #(
    .MULT_BITS (MULT_BITS)
  ) u_phase (
    .PCLK      (PCLK),
    .reset_n   (reset_n),
    .VSYNC_in  (VSYNC_in),
    .DE_in     (DE_in),
    .hmult     (sh.hmult),
    .vmult     (sh.vmult),
    .cfg_cap   (cfg_cap),
    .col_id    (col_id),
    .line_id   (line_id),
    .frame_odd (frame_odd)
  );

  // Configuration shadow, loaded only on the VSYNC leading edge.
  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      sh <= '0;
    end else if (cfg_cap) begin
      sh.mode    <= sl_mode_e'(cfg_mode);
      sh.alt     <= cfg_alt;
      sh.str     <= cfg_str;
      sh.slmask  <= cfg_slmask;
      sh.hmult   <= cfg_hmult;
      sh.vmult   <= cfg_vmult;
      sh.mask_br <= cfg_mask_br;
    end
  end

  assign str_v = OUT_BITS'(str_expand(sh.str, OUT_BITS));

  // Scanline hit decision for the pixel in S2, shared by all channels.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    hit   = 1'b0;
    h_hit = sh.slmask[s2_line] ^ (sh.alt & frame_odd);
    v_hit = (s2_col == '0);
    case (sh.mode)
      SL_H:    hit = h_hit;
      SL_V:    hit = v_hit;
      SL_HV:   hit = h_hit | v_hit;
      default: hit = 1'b0;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [IN_BITS-1:0]  ch_in;
    logic [OUT_BITS-1:0] ch_p2;
    logic [OUT_BITS-1:0] ch_p3;

    assign ch_in = s1_pix[c*IN_BITS +: IN_BITS];
    assign ch_p2 = s2_p[c*OUT_BITS +: OUT_BITS];
    assign ch_p3 = s3_p[c*OUT_BITS +: OUT_BITS];

    assign fade_nx[c*OUT_BITS +: OUT_BITS] =
      OUT_BITS'(fade_sat(32'(ch_in), 32'(s1_fade), OUT_BITS));
    assign sl_nx[c*OUT_BITS +: OUT_BITS] =
      !hit ? ch_p2 : ((ch_p2 > str_v) ? ch_p2 - str_v : '0);
    assign mask_nx[c*OUT_BITS +: OUT_BITS] =
      s3_mask ? {sh.mask_br, {(OUT_BITS-4){1'b0}}} : ch_p3;
  end

  // S1: register inputs and attach the pixel's column/line phase.
  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      s1_pix  <= '0;
      s1_fade <= '0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_de   <= 1'b0;
      s1_mask <= 1'b0;
      s1_col  <= '0;
      s1_line <= '0;
    end else begin
      s1_pix  <= pix_in;
      s1_fade <= fade_in;
      s1_hs   <= HSYNC_in;
      s1_vs   <= VSYNC_in;
      s1_de   <= DE_in;
      s1_mask <= mask_en_in;
      s1_col  <= col_id;
      s1_line <= line_id;
    end
  end

  // S2: fade multiply with saturation.
  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      s2_p    <= '0;
      s2_hs   <= 1'b1;
      s2_vs   <= 1'b1;
      s2_de   <= 1'b0;
      s2_mask <= 1'b0;
      s2_col  <= '0;
      s2_line <= '0;
    end else begin
      s2_p    <= fade_nx;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_de   <= s1_de;
      s2_mask <= s1_mask;
      s2_col  <= s1_col;
      s2_line <= s1_line;
    end
  end

  // S3: scanline darkening.
  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      s3_p    <= '0;
      s3_hs   <= 1'b1;
      s3_vs   <= 1'b1;
      s3_de   <= 1'b0;
      s3_mask <= 1'b0;
    end else begin
      s3_p    <= sl_nx;
      s3_hs   <= s2_hs;
      s3_vs   <= s2_vs;
      s3_de   <= s2_de;
      s3_mask <= s2_mask;
    end
  end

  // S4: border mask and output registers.
  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      pix_out   <= '0;
      HSYNC_out <= 1'b1;
      VSYNC_out <= 1'b1;
      DE_out    <= 1'b0;
    end else begin
      pix_out   <= mask_nx;
      HSYNC_out <= s3_hs;
      VSYNC_out <= s3_vs;
      DE_out    <= s3_de;
    end
  end

endmodule

// File: tb/tb_scanline_pp.sv
// Directed bench for scanline_pp: each driven cycle records its expected
// output, which is compared exactly four cycles later.
module tb_scanline_pp;

  logic        PCLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] pix_in = '0;
  logic [3:0]  fade_in = '0;
  logic        HSYNC_in = 1'b1;
  logic        VSYNC_in = 1'b1;
  logic        DE_in = 1'b0;
  logic        mask_en_in = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_alt = 1'b0;
  logic [3:0]  cfg_str = '0;
  logic [7:0]  cfg_slmask = '0;
  logic [2:0]  cfg_hmult = '0;
  logic [2:0]  cfg_vmult = '0;
  logic [3:0]  cfg_mask_br = '0;
  logic [23:0] pix_out;
  logic        HSYNC_out, VSYNC_out, DE_out, frame_odd;

  logic hs_drv = 1'b1;
  logic vs_drv = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic        chk;
    logic [23:0] pix;
    logic        hs;
    logic        vs;
    logic        de;
    string       tag;
  } exp_t;
  exp_t q[$];

  scanline_pp dut (
    .PCLK        (PCLK),
    .reset_n     (reset_n),
    .pix_in      (pix_in),
    .fade_in     (fade_in),
    .HSYNC_in    (HSYNC_in),
    .VSYNC_in    (VSYNC_in),
    .DE_in       (DE_in),
    .mask_en_in  (mask_en_in),
    .cfg_mode    (cfg_mode),
    .cfg_alt     (cfg_alt),
    .cfg_str     (cfg_str),
    .cfg_slmask  (cfg_slmask),
    .cfg_hmult   (cfg_hmult),
    .cfg_vmult   (cfg_vmult),
    .cfg_mask_br (cfg_mask_br),
    .pix_out     (pix_out),
    .HSYNC_out   (HSYNC_out),
    .VSYNC_out   (VSYNC_out),
    .DE_out      (DE_out),
    .frame_odd   (frame_odd)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; compare the outputs against the entry from 3 calls back.
  task automatic cyc(input logic [11:0] p, input logic [3:0] f, input logic de,
                     input logic m, input logic [23:0] e, input string tag);
    exp_t x;
    exp_t o;
    pix_in     = p;
    fade_in    = f;
    DE_in      = de;
    mask_en_in = m;
    HSYNC_in   = hs_drv;
    VSYNC_in   = vs_drv;
    @(posedge PCLK);
    #1;
    x.chk = de | m;
    x.pix = e;
    x.hs  = hs_drv;
    x.vs  = vs_drv;
    x.de  = de;
    x.tag = tag;
    q.push_back(x);
    if (q.size() == 4) begin
      o = q.pop_front();
      check({"ctl ", o.tag}, {29'd0, DE_out, HSYNC_out, VSYNC_out}, {29'd0, o.de, o.hs, o.vs});
      if (o.chk) check({"pix ", o.tag}, {8'd0, pix_out}, {8'd0, o.pix});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(12'h000, 4'h0, 1'b0, 1'b0, 24'h0, "idle");
  endtask

  // End of line: DE low with an HSYNC pulse in the middle.
  task automatic line_gap();
    idle(1);
    hs_drv = 1'b0;
    idle(2);
    hs_drv = 1'b1;
    idle(1);
  endtask

  task automatic vsync();
    vs_drv = 1'b0;
    idle(3);
    vs_drv = 1'b1;
    idle(2);
  endtask

  task automatic do_reset(input int n, input string tag);
    exp_t r;
    reset_n    = 1'b0;
    pix_in     = '0;
    fade_in    = '0;
    DE_in      = 1'b0;
    mask_en_in = 1'b0;
    hs_drv     = 1'b1;
    vs_drv     = 1'b1;
    HSYNC_in   = 1'b1;
    VSYNC_in   = 1'b1;
    repeat (n) @(posedge PCLK);
    #1;
    check({tag, " pix"},   {8'd0, pix_out}, 32'h0);
    check({tag, " hsync"}, {31'd0, HSYNC_out}, 32'h1);
    check({tag, " vsync"}, {31'd0, VSYNC_out}, 32'h1);
    check({tag, " de"},    {31'd0, DE_out}, 32'h0);
    check({tag, " odd"},   {31'd0, frame_odd}, 32'h0);
    reset_n = 1'b1;
    q.delete();
    r.chk = 1'b1; r.pix = '0; r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0; r.tag = "post-reset";
    repeat (3) q.push_back(r);
  endtask

  localparam logic [11:0] PA = 12'hAAA;
  localparam logic [23:0] NA = 24'hAAAAAA;
  localparam logic [23:0] DK = 24'h6B6B6B;

  initial begin
    // Reset, then fade with scanlines off; first pixel right after release.
    do_reset(3, "rst");
    cyc(12'hFFF, 4'hF, 1'b1, 1'b0, 24'hFFFFFF, "fade max");
    cyc(12'hF80, 4'h0, 1'b1, 1'b0, 24'h1E1000, "fade x2");
    cyc(12'h000, 4'h9, 1'b1, 1'b0, 24'h000000, "fade zero");
    cyc(12'hA31, 4'h5, 1'b1, 1'b0, 24'h461507, "fade x7");
    line_gap();

    // H scanlines: vmult=1, slmask bit 0, strength 3.
    cfg_mode = 2'd1; cfg_vmult = 3'd1; cfg_slmask = 8'h01; cfg_str = 4'd3;
    cfg_hmult = 3'd0; cfg_alt = 1'b0; cfg_mask_br = 4'h3;
    vsync();
    check("odd f1", {31'd0, frame_odd}, 32'h1);
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "h l0 a");
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "h l0 b");
    line_gap();
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "h l1");
    cyc(12'h333, 4'h0, 1'b1, 1'b0, 24'h060606, "h l1 dim");
    line_gap();
    cyc(12'h333, 4'h0, 1'b1, 1'b0, 24'h000000, "h l0 floor");
    line_gap();

    // cfg_alt changed mid-frame (odd frame, line 1): must not apply yet.
    cfg_alt = 1'b1;
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "alt shadow");
    line_gap();
    vsync();
    check("odd f2", {31'd0, frame_odd}, 32'h0);
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "alt even l0");
    line_gap();
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "alt even l1");
    line_gap();
    vsync();
    check("odd f3", {31'd0, frame_odd}, 32'h1);
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "alt odd l0");
    line_gap();
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "alt odd l1");
    line_gap();
    cfg_mode = 2'd0;
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "mode hold l0");
    line_gap();
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "mode hold l1");
    line_gap();
    vsync();
    check("odd f4", {31'd0, frame_odd}, 32'h0);
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "mode off l0");
    line_gap();

    // V scanlines, hmult=2: column 0 of every group of three.
    cfg_mode = 2'd2; cfg_hmult = 3'd2; cfg_alt = 1'b0;
    vsync();
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "v c0");
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "v c1");
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "v c2");
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "v c0 wrap");
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "v c1 wrap");
    line_gap();
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "v l1 c0");
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "v l1 c1");
    line_gap();

    // H+V: union of hits, single subtraction where both apply.
    cfg_mode = 2'd3;
    vsync();
    check("odd f6", {31'd0, frame_odd}, 32'h0);
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "hv l0 c0");
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "hv l0 c1");
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "hv l0 c2");
    line_gap();
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "hv l1 c0");
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "hv l1 c1");
    cyc(PA, 4'hF, 1'b1, 1'b0, NA, "hv l1 c2");
    line_gap();

    // Border mask overrides scanline hits and applies outside DE too.
    cyc(PA, 4'hF, 1'b1, 1'b1, 24'h303030, "mask hit");
    cyc(PA, 4'hF, 1'b1, 1'b1, 24'h303030, "mask c1");
    cyc(PA, 4'hF, 1'b0, 1'b1, 24'h303030, "mask blank");
    line_gap();

    // Reset with pixels in flight: they must never appear.
    cyc(PA, 4'hF, 1'b1, 1'b1, 24'h303030, "flight a");
    cyc(PA, 4'hF, 1'b1, 1'b0, DK, "flight b");
    do_reset(1, "mid rst");
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
